// File: rtl/noc_pkg.sv
// Shared mesh-router definitions: packet field positions and output port indices.
package noc_pkg;

  localparam int PKT_W_DEFAULT = 64;
  localparam int HOP_W_DEFAULT = 4;

  localparam int VC_BIT   = 63;
  localparam int DIRX_BIT = 62;
  localparam int DIRY_BIT = 61;
  localparam int HOPX_MSB = 55;
  localparam int HOPX_LSB = 52;
  localparam int HOPY_MSB = 51;
  localparam int HOPY_LSB = 48;

  localparam int PORT_E = 0;
  localparam int PORT_W = 1;
  localparam int PORT_N = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;
  localparam int NUM_PORTS = 5;

  typedef logic [NUM_PORTS-1:0] req_t;

endpackage

// File: rtl/route_compute.sv
// Dimension-ordered (X then Y) route for one packet, plus the forwarded packet
// with the consumed hop decremented and the VC flipped. Purely combinational.
module route_compute
  import noc_pkg::*;
#(
  parameter int PACKET_WIDTH = PKT_W_DEFAULT,
  parameter int HOP_W        = HOP_W_DEFAULT
) (
  input  logic [PACKET_WIDTH-1:0] i_pkt,
  output req_t                    o_req,
  output logic [PACKET_WIDTH-1:0] o_pkt
);

  logic [HOP_W-1:0] w_hop_x;
  logic [HOP_W-1:0] w_hop_y;

  assign w_hop_x = i_pkt[HOPX_MSB:HOPX_LSB];
  assign w_hop_y = i_pkt[HOPY_MSB:HOPY_LSB];

  always_comb begin
    o_req = '0;
    o_pkt = i_pkt;
    if (w_hop_x != '0) begin
      if (i_pkt[DIRX_BIT]) o_req[PORT_W] = 1'b1;
      else                 o_req[PORT_E] = 1'b1;
      o_pkt[HOPX_MSB:HOPX_LSB] = w_hop_x - 1'b1;
      o_pkt[VC_BIT]            = ~i_pkt[VC_BIT];
    end else if (w_hop_y != '0) begin
      if (i_pkt[DIRY_BIT]) o_req[PORT_S] = 1'b1;
      else                 o_req[PORT_N] = 1'b1;
      o_pkt[HOPY_MSB:HOPY_LSB] = w_hop_y - 1'b1;
      o_pkt[VC_BIT]            = ~i_pkt[VC_BIT];
    end else begin
      // Arrived: ejected to the local port untouched.
      o_req[PORT_L] = 1'b1;
    end
  end

endmodule

// File: rtl/router_input_port.sv
// Router input port: two single-packet VC buffers alternating between link
// write (VC ~polarity) and crossbar drain (VC polarity); also owns router polarity.
module router_input_port
  import noc_pkg::*;
#(
  parameter int PACKET_WIDTH = PKT_W_DEFAULT,
  parameter int HOP_W        = HOP_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    polarity,
  input  logic                    in_si,
  output logic                    in_ri,
  input  logic [PACKET_WIDTH-1:0] in_di,
  output logic                    out_valid,
  output logic [NUM_PORTS-1:0]    out_req,
  input  logic                    out_gnt,
  output logic [PACKET_WIDTH-1:0] out_data,
  output logic [1:0]              err
);

  logic                         r_polarity;
  logic [1:0]                   r_full;
  logic [1:0][PACKET_WIDTH-1:0] r_buf;
  logic [1:0][NUM_PORTS-1:0]    r_route;
  logic [1:0]                   r_err;

  logic                    w_ext_vc;
  req_t                    w_req;
  logic [PACKET_WIDTH-1:0] w_pkt;
  logic                    w_vc_bad;
  logic                    w_ovf;
  logic                    w_wr;
  logic                    w_drain;

  route_compute #(
    .PACKET_WIDTH (PACKET_WIDTH),
    .HOP_W        (HOP_W)
  ) u_route (
    .i_pkt (in_di),
    .o_req (w_req),
    .o_pkt (w_pkt)
  );

  assign w_ext_vc = ~r_polarity;
  // VC mismatch takes precedence: a wrong-VC packet is never counted as overflow.
  assign w_vc_bad = in_si && (in_di[VC_BIT] != w_ext_vc);
  assign w_ovf    = in_si && !w_vc_bad && r_full[w_ext_vc];
  assign w_wr     = in_si && !w_vc_bad && !r_full[w_ext_vc];
  assign w_drain  = out_gnt && r_full[r_polarity];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_polarity <= 1'b0;
      r_full     <= '0;
      r_buf      <= '0;
      r_route    <= '0;
      r_err      <= '0;
    end else begin
      r_polarity <= ~r_polarity;
      r_err      <= r_err | {w_ovf, w_vc_bad};
      // Write and drain always address opposite VCs, so both can land together.
      if (w_wr) begin
        r_buf[w_ext_vc]   <= w_pkt;
        r_route[w_ext_vc] <= w_req;
        r_full[w_ext_vc]  <= 1'b1;
      end
      if (w_drain) begin
        r_full[r_polarity] <= 1'b0;
      end
    end
  end

  assign polarity  = r_polarity;
  assign in_ri     = !r_full[r_polarity];
  assign out_valid = r_full[r_polarity];
  assign out_req   = out_valid ? r_route[r_polarity] : '0;
  assign out_data  = out_valid ? r_buf[r_polarity] : '0;
  assign err       = r_err;

endmodule
